mem_rmw_bridge: RTL and testbench

MEM_RMW_BRIDGE -- requirements
Module: mem_rmw_bridge

---
 rtl/mem_rmw_bridge_pkg.sv | 54 +++++
 rtl/mem_lane_align.sv | 18 +
 rtl/mem_rmw_bridge.sv | 183 ++++++++++++++++++
 tb/tb_mem_rmw_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rmw_bridge_pkg.sv
// Shared types and lane helpers for the load/store read-modify-write bridge.
// Byte offsets are little-endian: offset 0 is bits [7:0] of the memory word.
package mem_rmw_bridge_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        MERGE   = 2'b10,
        RESP    = 2'b11
    } state_e;

    function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SIZE_B:  err = 1'b0;
            SIZE_H:  err = off[0];
            SIZE_W:  err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            SIZE_B:  res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SIZE_H:  res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                               input logic [1:0] off, input logic [1:0] size);
        logic [31:0] mask;
        case (size)
            SIZE_B:  mask = 32'h0000_00FF;
            SIZE_H:  mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << {off, 3'b000};
        return (old_word & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: extended load extraction and store merge
// of right-aligned write data into the word read back from memory.
module mem_lane_align
    import mem_rmw_bridge_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    assign load_o  = lane_extract(word_i, off_i, size_i, unsigned_i);
    assign merge_o = lane_merge(word_i, wdata_i, off_i, size_i);

endmodule

// File: rtl/mem_rmw_bridge.sv
// Load/store front end for a read-first single-port RAM; sub-word stores are
// done as a read followed by a merged full-word write.
module mem_rmw_bridge
    import mem_rmw_bridge_pkg::*;
#(
    parameter int AddrBusWidth = 32,
    parameter int DataBusWidth = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [31:0]             req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [AddrBusWidth-1:0] mem_addr,
    output logic [DataBusWidth-1:0] mem_wdata,
    input  logic [DataBusWidth-1:0] mem_rdata
);

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;

    logic        accept_s;
    logic        mem_re_s;
    logic        mem_we_s;
    logic [31:0] mem_addr_s;
    logic [31:0] mem_wdata_s;
    logic [31:0] load_data_s;
    logic [31:0] merge_data_s;

    // Accepting is blocked while reset is held so no access leaks out during reset.
    assign accept_s = req_valid & req_ready_q & rst;

    mem_lane_align u_align (
        .word_i     (mem_rdata),
        .wdata_i    (wdata_q),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .load_o     (load_data_s),
        .merge_o    (merge_data_s)
    );

    // Next-state, capture and memory-command decode; the merge happens inside
    // the RD_WAIT cycle, so MERGE is never entered.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        mem_re_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = 32'h0000_0000;
        mem_wdata_s = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    req_ready_d = 1'b0;
                    addr_d      = {2'b00, req_addr[31:2]};
                    off_d       = req_addr[1:0];
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    we_d        = req_we;
                    wdata_d     = req_wdata;
                    rsp_rdata_d = 32'h0000_0000;
                    if (req_is_err(req_size, req_addr[1:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we && (req_size == SIZE_W)) begin
                        mem_we_s    = 1'b1;
                        mem_addr_s  = {2'b00, req_addr[31:2]};
                        mem_wdata_s = req_wdata;
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                    end else begin
                        mem_re_s   = 1'b1;
                        mem_addr_s = {2'b00, req_addr[31:2]};
                        state_d    = RD_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                mem_addr_s  = addr_q;
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                if (we_q) begin
                    mem_we_s    = 1'b1;
                    mem_wdata_s = merge_data_s;
                    rsp_rdata_d = 32'h0000_0000;
                end else begin
                    rsp_rdata_d = load_data_s;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'h0000_0000;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'h0000_0000;
            end
        endcase
    end

    // FSM state, captured request and registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            addr_q      <= 32'h0000_0000;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_re    = mem_re_s;
    assign mem_we    = mem_we_s;
    assign mem_addr  = AddrBusWidth'(mem_addr_s);
    assign mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_mem_rmw_bridge.sv
// Bench for mem_rmw_bridge: downstream RAM model, directed vector table,
// multi-cycle corner sequences and random traffic against a byte-array model.
module tb_mem_rmw_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:63];
    logic [7:0]  ref_b [0:255];
    logic        ram_clear;
    int          re_cnt;
    int          we_cnt;
    logic [31:0] last_widx;
    logic [31:0] last_wdata;
    int          checks;
    int          errors;

    mem_rmw_bridge #(.AddrBusWidth(32), .DataBusWidth(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first single-port RAM sitting below the bridge, plus access counters.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
            re_cnt <= 0;
            we_cnt <= 0;
        end else begin
            if (mem_we) begin
                ram[mem_addr[5:0]] <= mem_wdata;
                we_cnt     <= we_cnt + 1;
                last_widx  <= mem_addr;
                last_wdata <= mem_wdata;
            end
            if (mem_re) begin
                mem_rdata <= ram[mem_addr[5:0]];
                re_cnt    <= re_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int n;
        n = 1 << sz;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[(a + i) & 32'hFF]) << (8 * i));
        if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_apply(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic [31:0] wd);
        if (we && !model_err(a, sz)) begin
            for (int i = 0; i < (1 << sz); i++) ref_b[(a + i) & 32'hFF] = wd[8 * i +: 8];
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic e, output int lat,
                          output int nre, output int nwe);
        int re0;
        int we0;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout actual=0 expected=1");
        end
        re0 = re_cnt;
        we0 = we_cnt;
        req_valid    = 1'b1;
        req_addr     = a;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_addr     = $urandom;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 10);
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout actual=0 expected=1");
            lat = 99;
        end
        rd = rsp_rdata;
        e  = rsp_err;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("hold_rsp_rdata", rsp_rdata, rd);
            chk("hold_rsp_err", 32'(rsp_err), 32'(e));
            chk("hold_req_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        nre = re_cnt - re0;
        nwe = we_cnt - we0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_re;
        int          exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          nre;
        int          nwe;
        int          we0;
        logic [31:0] a;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] wd;
        logic        x_err;
        logic [31:0] x_rd;

        vecs[0]  = '{32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 1, 0, 1, 32'hDEADBEEF};
        vecs[1]  = '{32'h10, 1'b0, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0};
        vecs[2]  = '{32'h10, 1'b1, 2'd2, 1'b0, 32'h11223344, 32'h0,        1'b0, 1, 0, 1, 32'h11223344};
        vecs[3]  = '{32'h11, 1'b1, 2'd0, 1'b0, 32'h000000AA, 32'h0,        1'b0, 2, 1, 1, 32'h1122AA44};
        vecs[4]  = '{32'h10, 1'b0, 2'd2, 1'b0, 32'h0,        32'h1122AA44, 1'b0, 2, 1, 0, 32'h0};
        vecs[5]  = '{32'h20, 1'b1, 2'd2, 1'b0, 32'h80FF7F01, 32'h0,        1'b0, 1, 0, 1, 32'h80FF7F01};
        vecs[6]  = '{32'h22, 1'b0, 2'd0, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 0, 32'h0};
        vecs[7]  = '{32'h22, 1'b0, 2'd1, 1'b1, 32'h0,        32'h000080FF, 1'b0, 2, 1, 0, 32'h0};
        vecs[8]  = '{32'h20, 1'b0, 2'd0, 1'b0, 32'h0,        32'h00000001, 1'b0, 2, 1, 0, 32'h0};
        vecs[9]  = '{32'h03, 1'b0, 2'd1, 1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[10] = '{32'h02, 1'b1, 2'd2, 1'b0, 32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[11] = '{32'h20, 1'b0, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[12] = '{32'h21, 1'b1, 2'd3, 1'b0, 32'hCAFEF00D, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[13] = '{32'h22, 1'b0, 2'd1, 1'b0, 32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0, 32'h0};
        vecs[14] = '{32'h22, 1'b1, 2'd1, 1'b0, 32'hABCD1234, 32'h0,        1'b0, 2, 1, 1, 32'h12347F01};
        vecs[15] = '{32'h21, 1'b0, 2'd0, 1'b1, 32'h0,        32'h0000007F, 1'b0, 2, 1, 0, 32'h0};
        vecs[16] = '{32'h20, 1'b0, 2'd2, 1'b0, 32'h0,        32'h12347F01, 1'b0, 2, 1, 0, 32'h0};

        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;

        // Reset with a request pending: nothing may leak onto the memory port.
        rst          = 1'b0;
        ram_clear    = 1'b1;
        req_valid    = 1'b1;
        req_addr     = 32'h10;
        req_we       = 1'b1;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_wdata    = 32'hFFFF_FFFF;
        rsp_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_mem_re", 32'(mem_re), 32'h0);
        chk("reset_mem_we", 32'(mem_we), 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        req_valid = 1'b0;
        ram_clear = 1'b0;
        rst       = 1'b1;
        #1;
        chk("reset_release_req_ready", 32'(req_ready), 32'h1);

        for (int i = 0; i < 17; i++) begin
            do_req(vecs[i].addr, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].wdata, 0, rd, e, lat, nre, nwe);
            model_apply(vecs[i].addr, vecs[i].we, vecs[i].size, vecs[i].wdata);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_mem_re_count", i), 32'(nre), 32'(vecs[i].exp_re));
            chk($sformatf("vec%0d_mem_we_count", i), 32'(nwe), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we != 0) begin
                chk($sformatf("vec%0d_write_index", i), last_widx, vecs[i].addr >> 2);
                chk($sformatf("vec%0d_write_data", i), last_wdata, vecs[i].exp_wdata);
            end
        end

        // Response back-pressure: held 5 cycles, must not re-read memory.
        do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 5, rd, e, lat, nre, nwe);
        chk("bp_rdata", rd, 32'h1122AA44);
        chk("bp_latency", 32'(lat), 32'd2);
        chk("bp_mem_re_count", 32'(nre), 32'd1);
        chk("bp_mem_we_count", 32'(nwe), 32'd0);

        // Reset while a byte store sits in RD_WAIT: the write must be dropped.
        @(negedge clk);
        we0          = we_cnt;
        req_valid    = 1'b1;
        req_addr     = 32'h21;
        req_we       = 1'b1;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b0;
        #1;
        chk("rst_mid_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_req_ready", 32'(req_ready), 32'h1);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_write", 32'(we_cnt - we0), 32'h0);
        chk("rst_mid_no_response", 32'(rsp_valid), 32'h0);
        chk("rst_mid_ram_word", ram[8], 32'h12347F01);
        do_req(32'h20, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, e, lat, nre, nwe);
        chk("rst_mid_reload", rd, 32'h12347F01);

        for (int n = 0; n < 300; n++) begin
            a   = 32'($urandom_range(0, 255));
            we  = 1'($urandom);
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom);
            wd  = $urandom;
            x_err = model_err(a, sz);
            x_rd  = (x_err || we) ? 32'h0 : model_load(a, sz, uns);
            do_req(a, we, sz, uns, wd, $urandom_range(0, 2), rd, e, lat, nre, nwe);
            chk($sformatf("rnd%0d_rdata", n), rd, x_rd);
            chk($sformatf("rnd%0d_err", n), 32'(e), 32'(x_err));
            chk($sformatf("rnd%0d_latency", n), 32'(lat),
                (x_err || (we && sz == 2'd2)) ? 32'd1 : 32'd2);
            chk($sformatf("rnd%0d_mem_re_count", n), 32'(nre),
                (x_err || (we && sz == 2'd2)) ? 32'd0 : 32'd1);
            chk($sformatf("rnd%0d_mem_we_count", n), 32'(nwe), (!x_err && we) ? 32'd1 : 32'd0);
            model_apply(a, we, sz, wd);
        end

        for (int w = 0; w < 64; w++) begin
            chk($sformatf("final_ram_word%0d", w), ram[w],
                {ref_b[4 * w + 3], ref_b[4 * w + 2], ref_b[4 * w + 1], ref_b[4 * w]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
